// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: load/store width codes, lane count and the
// byte-lane helpers used by the data memory.
package riscv_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  // Byte-lane write enables for a store of the given width at byte offset off.
  function automatic logic [LANES-1:0] lane_enable(input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [LANES-1:0] be;
    be = 4'b0000;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = 4'b0011 << off;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Select the addressed lane of a memory word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h00_0000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Single-port block RAM with per-byte write enables and a registered read.
// Neither the array nor the read register is reset.
module bram_be
  import riscv_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic [LANES-1:0]         we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  output logic [31:0]              rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Byte-lane writes and synchronous read of the addressed word.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem.sv
// RV32 data memory: byte-addressed loads/stores over a valid/ready handshake
// with a single registered response slot and full-rate pass-through.
module data_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clock,
  input  logic          nReset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int           IW      = AW - 2;
  localparam int           ABW     = $clog2(DEPTH);
  // One extra bit so DEPTH is representable even when IW == ABW.
  localparam logic [IW:0]  DEPTH_W = (IW+1)'(DEPTH);

  rsp_state_e       state_r;
  rsp_state_e       state_nxt_s;
  logic             accept_s;
  logic [1:0]       off_s;
  logic [IW-1:0]    idx_s;
  logic             fmt_err_s;
  logic             oob_s;
  logic             err_s;
  logic [LANES-1:0] mem_we_s;
  logic             mem_re_s;
  logic [31:0]      wdata_rep_s;
  logic [31:0]      mem_rdata_s;
  logic             rsp_err_r;
  logic             rsp_load_r;
  logic [2:0]       rsp_f3_r;
  logic [1:0]       rsp_off_r;
  logic [31:0]      rsp_rdata_s;

  assign off_s     = req_addr[1:0];
  assign idx_s     = req_addr[AW-1:2];
  assign req_ready = (state_r == RSP_EMPTY) || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  assign oob_s     = ({1'b0, idx_s} >= DEPTH_W);
  assign err_s     = fmt_err_s || oob_s;

  // Width/alignment legality of the incoming request.
  always_comb begin
    fmt_err_s = 1'b0;
    case (req_funct3)
      F3_B:    fmt_err_s = 1'b0;
      F3_H:    fmt_err_s = off_s[0];
      F3_W:    fmt_err_s = (off_s != 2'b00);
      F3_BU:   fmt_err_s = req_we;
      F3_HU:   fmt_err_s = req_we || off_s[0];
      default: fmt_err_s = 1'b1;
    endcase
  end

  // Replicate store data across lanes; enables pick which lanes land.
  always_comb begin
    wdata_rep_s = req_wdata;
    case (req_funct3)
      F3_B:    wdata_rep_s = {4{req_wdata[7:0]}};
      F3_H:    wdata_rep_s = {2{req_wdata[15:0]}};
      default: wdata_rep_s = req_wdata;
    endcase
  end

  // Memory strobes: only legal, accepted requests touch the array.
  always_comb begin
    mem_we_s = 4'b0000;
    mem_re_s = 1'b0;
    if (accept_s && !err_s) begin
      if (req_we) begin
        mem_we_s = lane_enable(req_funct3, off_s);
        mem_re_s = 1'b0;
      end else begin
        mem_we_s = 4'b0000;
        mem_re_s = 1'b1;
      end
    end else begin
      mem_we_s = 4'b0000;
      mem_re_s = 1'b0;
    end
  end

  bram_be #(
    .DEPTH (DEPTH)
  ) u_bram (
    .clock (clock),
    .we    (mem_we_s),
    .addr  (idx_s[ABW-1:0]),
    .wdata (wdata_rep_s),
    .re    (mem_re_s),
    .rdata (mem_rdata_s)
  );

  // Response slot state register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= RSP_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response slot next state: fill on accept, drain when consumed without refill.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RSP_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = RSP_FULL;
        end else begin
          state_nxt_s = RSP_EMPTY;
        end
      end
      RSP_FULL: begin
        if (rsp_ready && !accept_s) begin
          state_nxt_s = RSP_EMPTY;
        end else begin
          state_nxt_s = RSP_FULL;
        end
      end
      default: state_nxt_s = RSP_EMPTY;
    endcase
  end

  // Capture response attributes at the accept edge; held otherwise.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rsp_err_r  <= 1'b0;
      rsp_load_r <= 1'b0;
      rsp_f3_r   <= 3'b000;
      rsp_off_r  <= 2'b00;
    end else if (accept_s) begin
      rsp_err_r  <= err_s;
      rsp_load_r <= !req_we && !err_s;
      rsp_f3_r   <= req_funct3;
      rsp_off_r  <= off_s;
    end
  end

  // Load data is extracted from the registered RAM word; zero otherwise.
  always_comb begin
    rsp_rdata_s = 32'h0000_0000;
    if ((state_r == RSP_FULL) && rsp_load_r) begin
      rsp_rdata_s = load_extend(rsp_f3_r, rsp_off_r, mem_rdata_s);
    end else begin
      rsp_rdata_s = 32'h0000_0000;
    end
  end

  assign rsp_valid = (state_r == RSP_FULL);
  assign rsp_err   = rsp_err_r && (state_r == RSP_FULL);
  assign rsp_rdata = rsp_rdata_s;

endmodule

// File: tb/tb_data_mem.sv
// Directed, table-driven bench for data_mem plus hand-written sequences for
// back-to-back, backpressure and mid-transaction reset.
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic          clock;
  logic          nReset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int n_chk;
  int n_fail;
  int acc_cnt;
  int rsp_cnt;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  data_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count request and response handshakes at each active edge.
  always @(posedge clock) begin
    if (nReset) begin
      if (req_valid && req_ready) acc_cnt++;
      if (rsp_valid && rsp_ready) rsp_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // One isolated transaction with rsp_ready held high.
  task automatic do_req(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clock);
    rsp_ready = 1'b1;
    drive(v.we, v.f3, v.addr, v.wdata);
    chk({nm, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    chk({nm, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({nm, ".rsp_err"},   {31'd0, rsp_err}, {31'd0, v.exp_err});
    @(negedge clock);
    chk({nm, ".rsp_drain"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; acc_cnt = 0; rsp_cnt = 0;
    nReset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

    vecs[0]  = mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 3'b000, 32'h11, 32'h80,       32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0);
    vecs[4]  = mk(1'b0, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0);
    vecs[5]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0);
    vecs[6]  = mk(1'b1, 3'b001, 32'h12, 32'h1234,     32'h0,        1'b0);
    vecs[7]  = mk(1'b0, 3'b001, 32'h12, 32'h0,        32'h00001234, 1'b0);
    vecs[8]  = mk(1'b0, 3'b101, 32'h13, 32'h0,        32'h0,        1'b1);
    vecs[9]  = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 1'b0);
    vecs[10] = mk(1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    vecs[11] = mk(1'b0, 3'b100, 32'h13, 32'h0,        32'h00000012, 1'b0);
    vecs[12] = mk(1'b1, 3'b010, 32'h00, 32'h01020304, 32'h0,        1'b0);
    vecs[13] = mk(1'b0, 3'b010, 32'h02, 32'h0,        32'h0,        1'b1);
    vecs[14] = mk(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,       1'b1);
    vecs[15] = mk(1'b1, 3'b010, 32'h80000010, 32'hCAFEF00D, 32'h0,  1'b1);
    vecs[16] = mk(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1);
    vecs[17] = mk(1'b1, 3'b011, 32'h10, 32'h11111111, 32'h0,        1'b1);
    vecs[18] = mk(1'b1, 3'b100, 32'h10, 32'h22,       32'h0,        1'b1);
    vecs[19] = mk(1'b1, 3'b101, 32'h10, 32'h3333,     32'h0,        1'b1);
    vecs[20] = mk(1'b1, 3'b001, 32'h11, 32'h4444,     32'h0,        1'b1);
    vecs[21] = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 1'b0);
    vecs[22] = mk(1'b0, 3'b010, 32'h00, 32'h0,        32'h01020304, 1'b0);
    vecs[23] = mk(1'b1, 3'b001, 32'h16, 32'h8001,     32'h0,        1'b0);
    vecs[24] = mk(1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFF8001, 1'b0);
    vecs[25] = mk(1'b0, 3'b101, 32'h16, 32'h0,        32'h00008001, 1'b0);
    vecs[26] = mk(1'b1, 3'b010, 32'h3FC, 32'hA5A55A5A, 32'h0,       1'b0);
    vecs[27] = mk(1'b0, 3'b010, 32'h3FC, 32'h0,       32'hA5A55A5A, 1'b0);
    vecs[28] = mk(1'b0, 3'b000, 32'h3FE, 32'h0,       32'hFFFFFFA5, 1'b0);
    vecs[29] = mk(1'b1, 3'b000, 32'h13, 32'h7F,       32'h0,        1'b0);
    vecs[30] = mk(1'b0, 3'b010, 32'h10, 32'h0,        32'h7F3480EF, 1'b0);

    // Reset state.
    #12;
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err",   {31'd0, rsp_err}, 32'd0);
    @(negedge clock);
    nReset = 1'b1;
    @(negedge clock);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i], i);
    end

    // Store then load to the same word on consecutive edges.
    @(negedge clock);
    rsp_ready = 1'b1;
    drive(1'b1, 3'b010, 32'h20, 32'h55667788);
    @(negedge clock);
    chk("b2b.st_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b.st_rdata", rsp_rdata, 32'd0);
    chk("b2b.req_ready", {31'd0, req_ready}, 32'd1);
    drive(1'b0, 3'b010, 32'h20, 32'h0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b.ld_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b.ld_rdata", rsp_rdata, 32'h55667788);
    chk("b2b.ld_err",   {31'd0, rsp_err}, 32'd0);
    @(negedge clock);
    chk("b2b.drain", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: hold the response three cycles, then hand off.
    @(negedge clock);
    rsp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clock);
    drive(1'b0, 3'b010, 32'h3FC, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d.req_ready", c), {31'd0, req_ready}, 32'd0);
      chk($sformatf("bp%0d.rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d.rsp_rdata", c), rsp_rdata, 32'h7F3480EF);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.handoff_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    chk("bp.new_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp.new_rdata", rsp_rdata, 32'hA5A55A5A);
    @(negedge clock);
    chk("bp.drain", {31'd0, rsp_valid}, 32'd0);
    chk("handshake_balance", rsp_cnt, acc_cnt);

    // Reset while a response is pending.
    @(negedge clock);
    rsp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("mrst.pre_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk("mrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst.rsp_rdata", rsp_rdata, 32'd0);
    chk("mrst.rsp_err",   {31'd0, rsp_err}, 32'd0);
    @(negedge clock);
    nReset = 1'b1;
    rsp_ready = 1'b1;
    do_req(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h7F3480EF, 1'b0), 100);
    do_req(mk(1'b0, 3'b010, 32'h20, 32'h0, 32'h55667788, 1'b0), 101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Parametrised RV32 data memory, successor to the fixed 32-word word-only RAM. Accepts byte-addressed load/store requests from the execute/memory stage over a valid/ready handshake, supports byte/half/word access with sign or zero extension, and returns a registered response with an error flag. It sits between the core's memory stage and on-chip block RAM, with one request accepted per cycle.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 16..65536.
- `AW`, 32: byte-address width; must satisfy AW ≥ log2(DEPTH)+2.

- `clock`  in  1  rising-edge clock.
- `nReset`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on edge where valid&&ready.
- `req_we`  in  1  1=store, 0=load.
- `req_funct3`  in  3  RV32 width/sign code (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101).
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed on edge where valid&&ready.
- `rsp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, out-of-range or illegal funct3.

## Operation
- `req_ready = !rsp_valid || rsp_ready`, so one outstanding response slot with full-rate pass-through.
- Word index = `req_addr[AW-1:2]`, offset = `req_addr[1:0]`.
- Error when any of these holds:
  - funct3 ∉ {000,001,010,100,101};
  - store with funct3 100/101;
  - half access with offset[0]=1;
  - word access with offset≠0;
  - word index ≥ DEPTH.
- Erroring requests never write memory.
- Store, no error: write only the addressed lanes at the accept edge.
  - Byte enables: SB = 0001<<off; SH = 0011<<off; SW = 1111.
  - Data replicated across lanes (byte ×4, half ×2).
- Load, no error: memory word read synchronously at the accept edge.
  - Lane selected by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
  - Extraction may be combinational from the registered word plus registered funct3/offset.
- Response: every accepted request (load, store, error) produces exactly one response.
- Response FSM: EMPTY → FULL on accept. In FULL:
  - rsp_ready && !accept → EMPTY;
  - rsp_ready && accept → stay FULL with new contents;
  - !rsp_ready → hold all rsp_* stable.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 once reset deasserts.
- Latency: request accepted at edge k → rsp_valid high from edge k, visible cycle k+1.
- Store followed by load to the same word on the next edge returns new data, because the write lands at edge k and the read happens at k+1.
- Reset asserted mid-transaction drops any pending response immediately. A store accepted on the same edge that reset asserts is not guaranteed to be written.
- Back-to-back throughput is 1 request/cycle while rsp_ready=1.

## Structure
- Shared `riscv_pkg`:
  - funct3 enum (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - lane-enable width constant (4).
- Sub-module `bram_be`:
  - parameters `DEPTH`;
  - ports `clock`, `we[3:0]`, `addr`, `wdata[31:0]`, `re`, `rdata[31:0]`;
  - registered read, per-byte write enables;
  - no reset on array or rdata.
- data_mem holds the error decode, lane/enable generation, the response register/FSM and the load extraction.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, err=0, one response each, first response cycle after accept.
- After the above: SB addr 0x11 data 0x80; LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080; LW 0x10 → 0xDEAD80EF.
- SH 0x12 data 0x1234, then LH 0x12 → 0x00001234; LHU 0x13 → err=1, rdata=0, memory unchanged.
- LW 0x02, SW with index=DEPTH, and funct3=011 → each err=1, no memory writes (check via readback).
- Hold rsp_ready=0 for 3 cycles after a load: req_ready=0 during the hold, response stable; then rsp_ready=1 with a new req_valid → handoff on the same edge, no lost or duplicated response.
- Assert nReset low while rsp_valid=1 → rsp_valid/rsp_rdata/rsp_err go 0 asynchronously; previously written memory still reads back after reset.
